// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - square-wave pulse channel: duty sequencer, frequency timer, length counter
module pulse_channel (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_en,
  input  logic       cpu_en,
  input  logic       clk1m_en,
  input  logic       clk256_en,
  input  logic [7:0] wr_data,
  input  logic       nr21_write,
  input  logic       nr23_write,
  input  logic       nr24_write,
  input  logic       dac_en,
  input  logic [3:0] amp,
  output logic       init,
  output logic       active,
  output logic [3:0] sample,
  output logic [7:0] nr21_rd,
  output logic [7:0] nr24_rd
);

  logic [1:0]  duty_q, duty_d;
  logic [10:0] freq_q, freq_d;
  logic        len_en_q, len_en_d;
  logic [6:0]  len_cnt_q, len_cnt_d;
  logic [10:0] timer_q, timer_d;
  logic [2:0]  step_q, step_d;
  logic        active_q, active_d;

  logic wr21, wr23, wr24, trig;
  logic tick_1m, tick_len;
  logic [7:0] pattern;
  logic       duty_bit;

  assign wr21     = cpu_en & nr21_write;
  assign wr23     = cpu_en & nr23_write;
  assign wr24     = cpu_en & nr24_write;
  assign trig     = wr24 & wr_data[7];
  assign tick_1m  = slow_clk_en & clk1m_en;
  assign tick_len = slow_clk_en & clk256_en & len_en_q & (len_cnt_q != 7'd0);

  // Waveform lookup: bit index is the duty step.
  always_comb begin
    pattern = 8'b1000_0000;
    case (duty_q)
      2'd0: pattern = 8'b1000_0000;
      2'd1: pattern = 8'b1000_0001;
      2'd2: pattern = 8'b1110_0001;
      2'd3: pattern = 8'b0111_1110;
      default: pattern = 8'b1000_0000;
    endcase
  end

  assign duty_bit = pattern[step_q];

  // Next-state: register writes, timer/step, length counter and channel enable.
  always_comb begin
    duty_d    = duty_q;
    freq_d    = freq_q;
    len_en_d  = len_en_q;
    len_cnt_d = len_cnt_q;
    timer_d   = timer_q;
    step_d    = step_q;
    active_d  = active_q;

    if (wr21) duty_d = wr_data[7:6];
    if (wr23) freq_d[7:0] = wr_data;
    if (wr24) begin
      freq_d[10:8] = wr_data[2:0];
      len_en_d     = wr_data[6];
    end

    // A length tick loses to both a length load and a trigger.
    if (tick_len && !trig && !wr21) len_cnt_d = len_cnt_q - 7'd1;
    if (wr21) len_cnt_d = 7'd64 - {1'b0, wr_data[5:0]};
    if (trig && (len_cnt_d == 7'd0)) len_cnt_d = 7'd64;

    // 2048 - freq in 11 bits is the two's complement of freq.
    if (trig) begin
      timer_d = 11'd0 - freq_d;
    end else if (tick_1m) begin
      if (timer_q == 11'd1) begin
        timer_d = 11'd0 - freq_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end

    if (trig) begin
      active_d = dac_en;
    end else if (!dac_en) begin
      active_d = 1'b0;
    end else if (tick_len && !wr21 && (len_cnt_q == 7'd1)) begin
      active_d = 1'b0;
    end else if (len_en_q && (len_cnt_q == 7'd0)) begin
      active_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= 2'd0;
      freq_q    <= 11'd0;
      len_en_q  <= 1'b0;
      len_cnt_q <= 7'd0;
      timer_q   <= 11'd0;
      step_q    <= 3'd0;
      active_q  <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      freq_q    <= freq_d;
      len_en_q  <= len_en_d;
      len_cnt_q <= len_cnt_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      active_q  <= active_d;
    end
  end

  assign init    = trig & ~reset;
  assign active  = active_q;
  assign sample  = (active_q & duty_bit) ? amp : 4'h0;
  assign nr21_rd = {duty_q, 6'h3F};
  assign nr24_rd = {1'b1, len_en_q, 6'h3F};

endmodule

// File: tb/tb_pulse_channel.sv
// tb/tb_pulse_channel.sv - table-driven scoreboard bench for pulse_channel
module tb_pulse_channel;

  logic       clk;
  logic       reset;
  logic       slow_clk_en, cpu_en, clk1m_en, clk256_en;
  logic [7:0] wr_data;
  logic       nr21_write, nr23_write, nr24_write;
  logic       dac_en;
  logic [3:0] amp;
  logic       init, active;
  logic [3:0] sample;
  logic [7:0] nr21_rd, nr24_rd;

  pulse_channel dut (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
    .clk1m_en(clk1m_en), .clk256_en(clk256_en), .wr_data(wr_data),
    .nr21_write(nr21_write), .nr23_write(nr23_write), .nr24_write(nr24_write),
    .dac_en(dac_en), .amp(amp), .init(init), .active(active), .sample(sample),
    .nr21_rd(nr21_rd), .nr24_rd(nr24_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {reset, cpu_en, nr21_write, nr23_write, nr24_write}; tk = {slow, clk1m, clk256}
  typedef struct packed {
    logic [4:0] ctl;
    logic [7:0] data;
    logic [2:0] tk;
    logic       dac;
    logic [3:0] amp;
    logic       e_init;
    logic       e_act;
    logic [3:0] e_smp;
    logic [7:0] e21;
    logic [7:0] e24;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idx = 0;
  string tag = "";
  logic [7:0] pat2 = 8'b1110_0001;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [7:0] d, input logic [2:0] tk,
                              input logic dac, input logic [3:0] a, input logic [1:0] ea,
                              input logic [3:0] es, input logic [7:0] e21, input logic [7:0] e24);
    vec_t v;
    v.ctl = ctl; v.data = d; v.tk = tk; v.dac = dac; v.amp = a;
    v.e_init = ea[1]; v.e_act = ea[0]; v.e_smp = es; v.e21 = e21; v.e24 = e24;
    return v;
  endfunction

  task automatic chk(input string what, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] %s: got %h want %h", tag, idx, what, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    logic init_seen;
    @(negedge clk);
    {reset, cpu_en, nr21_write, nr23_write, nr24_write} = v.ctl;
    wr_data = v.data;
    {slow_clk_en, clk1m_en, clk256_en} = v.tk;
    dac_en = v.dac;
    amp = v.amp;
    sb.push_back(v);
    #1;
    init_seen = init;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("init",   {7'd0, init_seen}, {7'd0, e.e_init});
    chk("active", {7'd0, active},    {7'd0, e.e_act});
    chk("sample", {4'd0, sample},    {4'd0, e.e_smp});
    chk("nr21_rd", nr21_rd, e.e21);
    chk("nr24_rd", nr24_rd, e.e24);
    idx++;
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b0; nr21_write = 1'b0; nr23_write = 1'b0; nr24_write = 1'b0;
    wr_data = 8'h00; slow_clk_en = 1'b0; clk1m_en = 1'b0; clk256_en = 1'b0;
    dac_en = 1'b0; amp = 4'h0;

    tbl.push_back(mk(5'b10000, 8'h00, 3'b000, 1'b0, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    tbl.push_back(mk(5'b00100, 8'hC0, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    tbl.push_back(mk(5'b00001, 8'hC7, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    tbl.push_back(mk(5'b01100, 8'hBE, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    tbl.push_back(mk(5'b01010, 8'hFF, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    tbl.push_back(mk(5'b01001, 8'hC7, 3'b000, 1'b1, 4'hF, 2'b11, 4'hF, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b101, 1'b1, 4'hF, 2'b01, 4'hF, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b001, 1'b1, 4'hF, 2'b01, 4'hF, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b101, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b101, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b01001, 8'hC7, 3'b101, 1'b1, 4'hF, 2'b11, 4'hF, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b000, 1'b0, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b01001, 8'hC7, 3'b000, 1'b0, 4'hF, 2'b10, 4'h0, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b01001, 8'hC7, 3'b000, 1'b1, 4'hF, 2'b11, 4'hF, 8'hBF, 8'hFF));
    tbl.push_back(mk(5'b11001, 8'hC7, 3'b111, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    tbl.push_back(mk(5'b01001, 8'h80, 3'b000, 1'b1, 4'hF, 2'b11, 4'h0, 8'h3F, 8'hBF));
    tbl.push_back(mk(5'b01100, 8'h40, 3'b101, 1'b1, 4'h5, 2'b01, 4'h5, 8'h7F, 8'hBF));
    tbl.push_back(mk(5'b00000, 8'h00, 3'b000, 1'b1, 4'hA, 2'b01, 4'hA, 8'h7F, 8'hBF));

    tag = "table";
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Trigger on an empty counter with a coincident length tick: 64 more ticks to expire.
    tag = "len64"; idx = 0;
    apply(mk(5'b10000, 8'h00, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    apply(mk(5'b01001, 8'hC0, 3'b101, 1'b1, 4'hF, 2'b11, 4'h0, 8'h3F, 8'hFF));
    for (int i = 1; i <= 64; i++)
      apply(mk(5'b00000, 8'h00, 3'b101, 1'b1, 4'hF, {1'b0, i < 64}, 4'h0, 8'h3F, 8'hFF));

    // Duty 2 at the fastest frequency: one step per timer tick.
    tag = "duty2"; idx = 0;
    apply(mk(5'b10000, 8'h00, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    apply(mk(5'b01100, 8'h80, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    apply(mk(5'b01010, 8'hFF, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    apply(mk(5'b01001, 8'h87, 3'b000, 1'b1, 4'hF, 2'b11, 4'hF, 8'hBF, 8'hBF));
    for (int k = 1; k <= 8; k++)
      apply(mk(5'b00000, 8'h00, 3'b110, 1'b1, 4'hF, 2'b01,
               pat2[k % 8] ? 4'hF : 4'h0, 8'hBF, 8'hBF));
    apply(mk(5'b00000, 8'h00, 3'b010, 1'b1, 4'hF, 2'b01, 4'hF, 8'hBF, 8'hBF));

    // Mid-period frequency change: period of 4 ticks finishes, then periods of 2.
    tag = "freq"; idx = 0;
    apply(mk(5'b10000, 8'h00, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'h3F, 8'hBF));
    apply(mk(5'b01100, 8'h80, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    apply(mk(5'b01010, 8'hFC, 3'b000, 1'b1, 4'hF, 2'b00, 4'h0, 8'hBF, 8'hBF));
    apply(mk(5'b01001, 8'h87, 3'b000, 1'b1, 4'hF, 2'b11, 4'hF, 8'hBF, 8'hBF));
    for (int t = 1; t <= 12; t++) begin
      if (t == 3)
        apply(mk(5'b01010, 8'hFE, 3'b000, 1'b1, 4'hF, 2'b01, 4'hF, 8'hBF, 8'hBF));
      apply(mk(5'b00000, 8'h00, 3'b110, 1'b1, 4'hF, 2'b01,
               (t < 4 || t >= 12) ? 4'hF : 4'h0, 8'hBF, 8'hBF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
